uart0_rxfifo: RTL
=================

# uart0_rxfifo

Receive-side buffer placed directly downstream of the `uart0` SFR block. It drains every completed byte out of `uart0`'s single receive buffer as soon as `scon.rxbfull` rises and pushes the byte plus its parity-error bit into a DEPTH-entry FIFO. The CPU reads the FIFO through its own SFRs, so the CPU can fall up to DEPTH frames behind the line without losing data.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Legal values are 2, 4 and 8.
- `AW`, 3: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `uart_scon`  in  8  `uart0` `scon`. Bit 0 is rxbfull and bit 6 is chkerr.
- `uart_sbuf`  in  8  `uart0` `sbuf` (received byte).
- `uart_sbuf_rctrl`  out  1  one-cycle read strobe into `uart0`. It clears rxbfull.
- `rfdat`  out  8  FIFO head data (show-ahead).
- `rfdat_rctrl`  in  1  CPU read of `rfdat`. Pops the FIFO.
- `rfsta`  out  8  {ovf, full, empty, perr_head, level[3:0]}.
- `rfsta_wctrl`  in  1  SFR write strobe for `rfsta`.
- `rfctl`  out  8  {rfen, flush, ovf_ie, thr_ie, thr[3:0]}.
- `rfctl_wctrl`  in  1  SFR write strobe for `rfctl`.
- `sfr_wdata`  in  8  SFR write data.
- `rf_int`  out  1  interrupt request, level-sensitive.

## Operation
**Drain state machine** (states IDLE, READ, HOLD):
- IDLE → READ when `rfen & rxbfull`.
- READ lasts one cycle.
  - `uart_sbuf_rctrl` = 1.
  - The entry {chkerr, `uart_sbuf`} is captured and pushed at the end of the cycle.
  - READ → HOLD.
- HOLD lasts one guard cycle while rxbfull clears in `uart0`. HOLD → IDLE.
- Throughput is 3 clk per byte. This is far faster than any frame time.

**Push when full:**
- If the FIFO is full and no pop happens in the same cycle, the captured byte is dropped and `ovf` is set (sticky).
- The drain still completes, so `uart0` is never left blocked.

**Pop:**
- `rfdat_rctrl` while not empty pops the head.
- `rfdat_rctrl` while empty is ignored; level and pointers are unchanged.
- When empty, `rfdat` and `perr_head` read 0.

**Simultaneous push and pop:**
- Both take effect and level is unchanged.
- This applies even when the FIFO is full: the push is accepted and `ovf` is not set.

**Writes to `rfctl`:**
- Writing `rfctl` loads all 8 bits.
- `flush` self-clears on the next cycle. While it is 1, both pointers and level go to 0.
- Flush wins over a push or pop in the same cycle; that push is discarded and `ovf` is not set.

**Writes to `rfsta`:**
- Writing `rfsta` with bit 7 = 0 clears `ovf`. All other bits are read-only.
- If an overflow happens in the same cycle as the clear, `ovf` stays set.

**Disable:**
- `rfen` = 0 forces the FSM to IDLE, with no further strobes.
- A READ already in flight still completes its push.
- FIFO contents are retained.

**Interrupt:**
- `rf_int = (thr_ie & level >= max(thr,1)) | (ovf_ie & ovf)`.

**Arithmetic:**
- Pointers are AW bits and wrap modulo DEPTH.
- Level is AW+1 bits, range 0..DEPTH, zero-extended into `rfsta[3:0]`.
- `full` = (level == DEPTH). `empty` = (level == 0).

## Timing
- Reset values:
  - `rfsta` = 8'h20 (only empty = 1).
  - `rfctl` = 8'h00.
  - `rfdat` = 0, `uart_sbuf_rctrl` = 0, `rf_int` = 0.
  - FSM = IDLE.
- Reset taken during READ or HOLD: the push is abandoned and all state returns to the reset values on the next edge.
- rxbfull sampled 1 in cycle t (FSM in IDLE) gives:
  - `uart_sbuf_rctrl` = 1 in cycle t+1;
  - the entry visible on `rfdat`/`rfsta` in cycle t+2;
  - IDLE again in cycle t+3.
- `rfsta`, `rf_int` and `rfdat` update the cycle after a push, pop or flush. All outputs are registered or decoded from registers; there are no combinational paths from inputs.
- The SFR bus guarantees that `rfdat_rctrl` is a one-cycle strobe.

## Structure
- Package `uart0_rxfifo_pkg` holds:
  - the FSM state enum (IDLE, READ, HOLD);
  - `rfsta` and `rfctl` bit-position constants;
  - the `scon` bit indices RXBFULL = 0 and CHKERR = 6.
- Sub-module `uart0_fifo_mem` is a synchronous 9-bit × DEPTH register-array FIFO with pointers, level, push, pop and flush. Its head output is show-ahead.
- The top level holds the drain FSM, SFR registers, overflow logic and interrupt decode.

## Test plan
- **Single byte.** Set `rfctl` = 8'h81 and pulse rxbfull with `sbuf` = 8'hA5, chkerr = 0. Expect one `uart_sbuf_rctrl` pulse and `rfsta` = 8'h01. Expect `rf_int` = 0 (thr_ie = 0). Expect `rfdat` = 8'hA5.
- **Pop, then pop on empty.** Pop that byte: `rfsta` = 8'h20. A further `rfdat_rctrl` leaves `rfsta` = 8'h20 and `rfdat` = 0.
- **Overflow.** Push 9 bytes 8'h01..8'h09 with no pop. Expect `rfsta` = 8'hC8, i.e. ovf = 1, full = 1, level = 8. `rfdat` must read 8'h01; 8'h09 is dropped. With `ovf_ie` = 1, expect `rf_int` = 1. Writing `rfsta` = 8'h00 clears ovf.
- **Parity and threshold.** Set `rfctl` = 8'h93 (thr_ie, thr = 3). Push 8'h11 (chkerr = 1), then 8'h22 and 8'h33. Expect `rf_int` to go to 1 the cycle after the third push, and `perr_head` = 1. After one pop: `perr_head` = 0 and `rf_int` = 0.
- **Full FIFO with simultaneous push and pop.** With the FIFO full, assert `rfdat_rctrl` in the same cycle the drain pushes. Expect level to stay 8 and ovf to stay 0.
- **Flush and reset.** Flush while a READ is in progress: level = 0 and the push is discarded. Also assert `rst` = 0 mid-HOLD: all outputs return to their reset values and the FSM returns to IDLE.

Source files
------------

// File: rtl/uart0_rxfifo_pkg.sv
// Shared definitions for the uart0 receive FIFO: drain FSM states, SFR bit
// positions and the threshold helper used by the interrupt decode.
package uart0_rxfifo_pkg;

    // Drain state machine that moves bytes out of uart0's single receive buffer
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_READ = 2'd1,
        DRAIN_HOLD = 2'd2
    } drain_state_e;

    // uart0 scon bit indices
    localparam int SCON_RXBFULL = 0;
    localparam int SCON_CHKERR  = 6;

    // rfsta bit positions: {ovf, full, empty, perr_head, level[3:0]}
    localparam int STA_OVF   = 7;
    localparam int STA_FULL  = 6;
    localparam int STA_EMPTY = 5;
    localparam int STA_PERR  = 4;

    // rfctl bit positions: {rfen, flush, ovf_ie, thr_ie, thr[3:0]}
    localparam int CTL_RFEN   = 7;
    localparam int CTL_FLUSH  = 6;
    localparam int CTL_OVF_IE = 5;
    localparam int CTL_THR_IE = 4;
    localparam int CTL_THR_HI = 3;
    localparam int CTL_THR_LO = 0;

    // FIFO entry: {parity error, data byte}
    localparam int ENTRY_W = 9;

    // A threshold of zero behaves as one so an empty FIFO never interrupts
    function automatic logic [4:0] thr_effective(input logic [3:0] thr);
        logic [4:0] eff;
        if (thr == 4'd0) begin
            eff = 5'd1;
        end else begin
            eff = {1'b0, thr};
        end
        return eff;
    endfunction

endpackage

// File: rtl/uart0_fifo_mem.sv
// Register-array FIFO of {perr, byte} entries with show-ahead head output.
// Pop on empty and push on full (without a same-cycle pop) are ignored here;
// the parent decides what a dropped push means. Flush overrides everything.
module uart0_fifo_mem
    import uart0_rxfifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [AW:0]        level_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Qualify push/pop and compute next pointers and level
    always_comb begin
        pop_ok_s  = pop_i & (level_q != {(AW+1){1'b0}});
        push_ok_s = push_i & ((level_q != DEPTH_L) | pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; a flushed push is never written
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart0_rxfifo.sv
// Receive FIFO behind uart0: drains each completed byte (READ strobe, then a
// HOLD guard cycle while rxbfull clears) into a DEPTH-entry FIFO that the CPU
// reads through rfdat/rfsta/rfctl. Sticky overflow and a level interrupt.
module uart0_rxfifo
    import uart0_rxfifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_scon,
    input  logic [7:0] uart_sbuf,
    output logic       uart_sbuf_rctrl,
    output logic [7:0] rfdat,
    input  logic       rfdat_rctrl,
    output logic [7:0] rfsta,
    input  logic       rfsta_wctrl,
    output logic [7:0] rfctl,
    input  logic       rfctl_wctrl,
    input  logic [7:0] sfr_wdata,
    output logic       rf_int
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    drain_state_e       state_q, state_d;
    logic [7:0]         rfctl_q, rfctl_d;
    logic               ovf_q, ovf_d;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic [AW:0]        level_s;
    logic [3:0]         level4_s;
    logic               rfen_s;
    logic               flush_s;
    logic               push_s;
    logic               full_s;
    logic               empty_s;
    logic               drop_s;
    logic               perr_head_s;
    logic               unused_scon_s;

    assign rfen_s        = rfctl_q[CTL_RFEN];
    assign flush_s       = rfctl_q[CTL_FLUSH];
    assign push_s        = (state_q == DRAIN_READ);
    assign entry_s       = {uart_scon[SCON_CHKERR], uart_sbuf};
    assign full_s        = (level_s == DEPTH_L);
    assign empty_s       = (level_s == {(AW+1){1'b0}});
    // A push is lost only when full, not popped in the same cycle, and not flushed
    assign drop_s        = push_s & full_s & ~rfdat_rctrl & ~flush_s;
    assign unused_scon_s = ^{uart_scon[7], uart_scon[5:1]};

    uart0_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (rfdat_rctrl),
        .flush_i (flush_s),
        .wdata_i (entry_s),
        .head_o  (head_s),
        .level_o (level_s)
    );

    // Drain FSM next state; clearing rfen parks it in IDLE
    always_comb begin
        state_d = state_q;
        if (!rfen_s) begin
            state_d = DRAIN_IDLE;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (uart_scon[SCON_RXBFULL]) begin
                        state_d = DRAIN_READ;
                    end else begin
                        state_d = DRAIN_IDLE;
                    end
                end
                DRAIN_READ: state_d = DRAIN_HOLD;
                DRAIN_HOLD: state_d = DRAIN_IDLE;
                default:    state_d = DRAIN_IDLE;
            endcase
        end
    end

    // Control register: full load on write, otherwise flush self-clears
    always_comb begin
        rfctl_d = rfctl_q;
        if (rfctl_wctrl) begin
            rfctl_d = sfr_wdata;
        end else begin
            rfctl_d[CTL_FLUSH] = 1'b0;
        end
    end

    // Sticky overflow: a same-cycle overflow beats a software clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (rfsta_wctrl && !sfr_wdata[STA_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, control and overflow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DRAIN_IDLE;
            rfctl_q <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rfctl_q <= rfctl_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        level4_s         = 4'd0;
        level4_s[AW:0]   = level_s;
        perr_head_s      = empty_s ? 1'b0 : head_s[ENTRY_W-1];
        rfdat            = empty_s ? 8'h00 : head_s[7:0];
        rfsta            = 8'h00;
        rfsta[STA_OVF]   = ovf_q;
        rfsta[STA_FULL]  = full_s;
        rfsta[STA_EMPTY] = empty_s;
        rfsta[STA_PERR]  = perr_head_s;
        rfsta[3:0]       = level4_s;
        rf_int = (rfctl_q[CTL_THR_IE]
                  & ({1'b0, level4_s} >= thr_effective(rfctl_q[CTL_THR_HI:CTL_THR_LO])))
               | (rfctl_q[CTL_OVF_IE] & ovf_q);
    end

    assign uart_sbuf_rctrl = (state_q == DRAIN_READ);
    assign rfctl           = rfctl_q;

endmodule
